// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT modules.
//   fft_state_e    - sequencer state encoding
//   fft_log2()     - ceil(log2(n)), used to derive the stage count from N
//   fft_idx_width()- stage-index width, max(1, clog2(log2n))
//   FFT_*_DEFAULT  - stage count and index width for the default N=16
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } fft_state_e;

    function automatic int unsigned fft_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned fft_idx_width(input int unsigned log2n);
        int unsigned w;
        w = fft_log2(log2n);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int unsigned FFT_N_DEFAULT     = 16;
    localparam int unsigned FFT_LOG2N_DEFAULT = fft_log2(FFT_N_DEFAULT);
    localparam int unsigned FFT_IDX_W_DEFAULT = fft_idx_width(FFT_LOG2N_DEFAULT);

endpackage

// File: rtl/fft_sequencer.sv
// fft_sequencer: steps a radix-2 FFT through its LOG2N stages, ping-ponging
// between two buffer banks and watching each stage for a timeout.
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   start       - request a full FFT (honoured in IDLE or ERR only)
//   bf_valid    - butterfly bank reports the current stage finished
//   stage_start - one-cycle launch pulse for the current stage
//   stage_idx   - current stage, 0..LOG2N-1
//   buf_sel     - source bank; the destination is !buf_sel
//   tw_stride   - twiddle address stride, N >> (stage_idx+1)
//   wr_en       - one-cycle strobe writing stage results to the destination
//   busy        - high in ISSUE, WAIT and WRITE
//   done        - one-cycle pulse after the final stage write
//   err         - held while the sequencer sits in ERR after a timeout
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  bf_valid,
    output logic                                  stage_start,
    output logic [fft_idx_width(fft_log2(N))-1:0] stage_idx,
    output logic                                  buf_sel,
    output logic [fft_log2(N)-1:0]                tw_stride,
    output logic                                  wr_en,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int unsigned LOG2N = fft_log2(N);
    localparam int unsigned IDX_W = fft_idx_width(LOG2N);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    fft_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_d;
    logic              bsel_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stage_idx <= '0;
            buf_sel   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            stage_idx <= idx_d;
            buf_sel   <= bsel_d;
            tmo_cnt   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = stage_idx;
        bsel_d  = buf_sel;
        tmo_d   = tmo_cnt;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    bsel_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                // tmo_cnt holds the number of WAIT cycles already elapsed,
                // so TIMEOUT-1 marks the last allowed cycle; bf_valid wins.
                if (bf_valid) begin
                    state_d = ST_WRITE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                end
            end
            ST_WRITE: begin
                bsel_d = ~buf_sel;
                if (stage_idx == IDX_W'(LOG2N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = stage_idx + IDX_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stage_start = (state_q == ST_ISSUE);
        wr_en       = (state_q == ST_WRITE);
        done        = (state_q == ST_DONE);
        err         = (state_q == ST_ERR);
        busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
        tw_stride   = LOG2N'(N >> (int'(stage_idx) + 1));
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed bench for fft_sequencer (N=16, TIMEOUT=4).
// Each step drives one cycle of inputs and queues the outputs expected in
// the following cycle; a checker pops one entry after every rising edge.
module tb_fft_sequencer;

    typedef struct packed {
        logic       stage_start;
        logic       wr_en;
        logic       done;
        logic       busy;
        logic       err;
        logic [1:0] stage_idx;
        logic       buf_sel;
        logic [3:0] tw_stride;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       bf_valid;
    logic       stage_start;
    logic [1:0] stage_idx;
    logic       buf_sel;
    logic [3:0] tw_stride;
    logic       wr_en;
    logic       busy;
    logic       done;
    logic       err;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks;
    int    n_fail;
    obs_t  exp_v;
    obs_t  obs_v;
    string tag_v;
    obs_t  rst_exp;

    fft_sequencer #(
        .N       (16),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bf_valid    (bf_valid),
        .stage_start (stage_start),
        .stage_idx   (stage_idx),
        .buf_sel     (buf_sel),
        .tw_stride   (tw_stride),
        .wr_en       (wr_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic ss, input logic wr, input logic dn,
                                input logic bs, input logic er, input logic [1:0] idx,
                                input logic bsel, input logic [3:0] tw);
        obs_t o;
        o.stage_start = ss;
        o.wr_en       = wr;
        o.done        = dn;
        o.busy        = bs;
        o.err         = er;
        o.stage_idx   = idx;
        o.buf_sel     = bsel;
        o.tw_stride   = tw;
        return o;
    endfunction

    // Expected outputs in cycle c of an undisturbed run whose start was
    // sampled in cycle 0 and whose bf_valid arrives one cycle after each
    // stage_start: ISSUE/WAIT/WRITE per stage, DONE at 13, IDLE at 14.
    function automatic obs_t nom_exp(input int c);
        int k;
        int ph;
        if (c <= 12) begin
            k  = (c - 1) / 3;
            ph = (c - 1) % 3;
            return mk(ph == 0, ph == 2, 1'b0, 1'b1, 1'b0, 2'(k), 1'(k % 2), 4'(8 >> k));
        end else if (c == 13) begin
            return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd1);
        end
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'd1);
    endfunction

    task automatic step(input logic s, input logic b, input logic r,
                        input obs_t e, input string t);
        @(negedge clk);
        start    = s;
        bf_valid = b;
        rst      = r;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            obs_v = {stage_start, wr_en, done, busy, err, stage_idx, buf_sel, tw_stride};
            n_checks++;
            assert (obs_v === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed ss=%b wr=%b dn=%b busy=%b err=%b idx=%0d bsel=%b tw=%0d expected ss=%b wr=%b dn=%b busy=%b err=%b idx=%0d bsel=%b tw=%0d",
                       tag_v,
                       obs_v.stage_start, obs_v.wr_en, obs_v.done, obs_v.busy, obs_v.err,
                       obs_v.stage_idx, obs_v.buf_sel, obs_v.tw_stride,
                       exp_v.stage_start, exp_v.wr_en, exp_v.done, exp_v.busy, exp_v.err,
                       exp_v.stage_idx, exp_v.buf_sel, exp_v.tw_stride);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        bf_valid = 1'b0;
        rst_exp  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd8);

        // Reset state
        step(1'b0, 1'b0, 1'b1, rst_exp, "reset0");
        step(1'b0, 1'b0, 1'b1, rst_exp, "reset1");

        // Nominal four-stage run
        for (int c = 0; c <= 13; c++) begin
            step(c == 0, (c == 2) || (c == 5) || (c == 8) || (c == 11), 1'b0,
                 nom_exp(c + 1), $sformatf("nominal_c%0d", c + 1));
        end

        // Timeout after four WAIT cycles, ERR holds, restart clears err
        step(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 2'd0, 0, 4'd8), "tmo_issue");
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 2'd0, 0, 4'd8), $sformatf("tmo_wait%0d", c));
        end
        step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 2'd0, 0, 4'd8), "tmo_err");
        step(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 2'd0, 0, 4'd8), "err_hold");
        step(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 2'd0, 0, 4'd8), "err_restart");

        // bf_valid on the fourth WAIT cycle beats the timeout
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 2'd0, 0, 4'd8), $sformatf("edge_wait%0d", c));
        end
        step(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 1, 0, 2'd0, 0, 4'd8), "edge_write");
        step(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 2'd1, 1, 4'd4), "s1_issue");
        step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 2'd1, 1, 4'd4), "s1_wait");
        step(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 1, 0, 2'd1, 1, 4'd4), "s1_write");
        step(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 2'd2, 0, 4'd2), "s2_issue");
        step(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 2'd2, 0, 4'd2), "s2_wait");

        // Reset in WAIT of stage 2 beats bf_valid and start
        step(1'b1, 1'b1, 1'b1, rst_exp, "abort_rst");
        step(1'b0, 1'b0, 1'b0, rst_exp, "abort_idle");

        // start held high, bf_valid held high: stray pulses ignored,
        // single run, next run launches the cycle after returning to IDLE
        for (int c = 0; c <= 13; c++) begin
            step(1'b1, 1'b1, 1'b0, nom_exp(c + 1), $sformatf("held_c%0d", c + 1));
        end
        step(1'b1, 1'b1, 1'b0, mk(1, 0, 0, 1, 0, 2'd0, 0, 4'd8), "held_rerun");
        step(1'b0, 1'b0, 1'b1, rst_exp, "final_rst");

        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
